ifft8_iter: RTL and testbench

//  8-point inverse DFT, radix-2 DIT, one shared butterfly iterated over 3 stages x 4 butterflies.

---
 rtl/ifft8_iter.sv | 197 +++++++++++++++++++
 tb/tb_ifft8_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_iter.sv
// 8-point inverse DFT, radix-2 DIT, single shared butterfly iterated 3 stages x 4 butterflies.
// Bins stream in over valid/ready, samples (scaled by 1/8) stream out over valid/ready.
module ifft8_iter #(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = DW + 1;
  localparam longint unsigned UNITY = longint'(1) << (TW - 2);
  localparam longint unsigned C45   = (UNITY * 46341) >> 16;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_UNLD = 2'd2;

  logic [1:0] state, state_nxt;
  logic [2:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0] bfc, bfc_nxt;
  logic       in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
  logic [DW-1:0] out_re_nxt, out_im_nxt;
  logic       ld_we, bf_we;

  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  logic [2:0] top_idx, bot_idx, ld_idx;
  logic [1:0] tw_k;
  logic signed [TW-1:0] tw_re, tw_im;
  logic signed [DW-1:0] top_re, top_im, bot_re, bot_im;
  logic signed [PW-1:0] pr, pi;
  logic signed [SW-1:0] t_re, t_im, sum_re, sum_im, dif_re, dif_im;

  assign cnt_inc = 3'(cnt + 3'd1);
  assign ld_idx  = {cnt[0], cnt[1], cnt[2]};

  // Butterfly addressing: stage in bfc[3:2], butterfly index in bfc[1:0]
  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    tw_k    = '0;
    case (bfc[3:2])
      2'd0: begin
        top_idx = {bfc[1:0], 1'b0};
        bot_idx = {bfc[1:0], 1'b1};
        tw_k    = 2'd0;
      end
      2'd1: begin
        top_idx = {bfc[1], 1'b0, bfc[0]};
        bot_idx = {bfc[1], 1'b1, bfc[0]};
        tw_k    = {bfc[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, bfc[1:0]};
        bot_idx = {1'b1, bfc[1:0]};
        tw_k    = bfc[1:0];
      end
    endcase
  end

  // Twiddle W^-k = cos(pi*k/4) + j*sin(pi*k/4)
  always_comb begin
    tw_re = TW'(UNITY);
    tw_im = '0;
    case (tw_k)
      2'd1: begin tw_re = TW'(C45);  tw_im = TW'(C45);   end
      2'd2: begin tw_re = '0;        tw_im = TW'(UNITY); end
      2'd3: begin tw_re = -TW'(C45); tw_im = TW'(C45);   end
      default: begin tw_re = TW'(UNITY); tw_im = '0;     end
    endcase
  end

  always_comb begin
    top_re = mem_re[top_idx];
    top_im = mem_im[top_idx];
    bot_re = mem_re[bot_idx];
    bot_im = mem_im[bot_idx];
    pr     = PW'(bot_re) * PW'(tw_re) - PW'(bot_im) * PW'(tw_im);
    pi     = PW'(bot_re) * PW'(tw_im) + PW'(bot_im) * PW'(tw_re);
    t_re   = SW'(pr >>> (TW - 2));
    t_im   = SW'(pi >>> (TW - 2));
    sum_re = SW'(top_re) + t_re;
    sum_im = SW'(top_im) + t_im;
    dif_re = SW'(top_re) - t_re;
    dif_im = SW'(top_im) - t_im;
  end

  // Buffer holds no reset: contents are rewritten by every frame
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_re[ld_idx] <= in_re;
      mem_im[ld_idx] <= in_im;
    end else if (bf_we) begin
      mem_re[top_idx] <= DW'(sum_re >>> 1);
      mem_im[top_idx] <= DW'(sum_im >>> 1);
      mem_re[bot_idx] <= DW'(dif_re >>> 1);
      mem_im[bot_idx] <= DW'(dif_im >>> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      cnt       <= '0;
      bfc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bfc       <= bfc_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      out_re    <= out_re_nxt;
      out_im    <= out_im_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bfc_nxt       = bfc;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    out_re_nxt    = out_re;
    out_im_nxt    = out_im;
    ld_we         = 1'b0;
    bf_we         = 1'b0;
    case (state)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          ld_we   = 1'b1;
          cnt_nxt = cnt_inc;
          if (cnt == 3'd7) begin
            state_nxt    = S_COMP;
            in_ready_nxt = 1'b0;
          end
        end
      end
      S_COMP: begin
        bf_we   = 1'b1;
        bfc_nxt = 4'(bfc + 4'd1);
        if (bfc == 4'd11) begin
          bfc_nxt   = '0;
          state_nxt = S_UNLD;
        end
      end
      S_UNLD: begin
        // First UNLOAD cycle only stages sample 0 into the output register
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
          out_re_nxt    = mem_re[cnt];
          out_im_nxt    = mem_im[cnt];
          out_last_nxt  = (cnt == 3'd7);
        end else if (out_ready) begin
          if (cnt == 3'd7) begin
            state_nxt     = S_LOAD;
            cnt_nxt       = '0;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            in_ready_nxt  = 1'b1;
          end else begin
            cnt_nxt      = cnt_inc;
            out_re_nxt   = mem_re[cnt_inc];
            out_im_nxt   = mem_im[cnt_inc];
            out_last_nxt = (cnt_inc == 3'd7);
          end
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
    busy_nxt = (state_nxt != S_LOAD);
  end

endmodule

// File: tb/tb_ifft8_iter.sv
// Bench for ifft8_iter: directed and random frames checked against a floating-point inverse DFT.
`timescale 1ns/1ps
module tb_ifft8_iter;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e_cyc = 0;
  int tx_re[8], tx_im[8], rx_re[8], rx_im[8], sv_re[8], sv_im[8];

  ifft8_iter #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp, input int tol);
    longint d;
    total++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  task automatic clear_tx();
    for (int k = 0; k < 8; k++) begin tx_re[k] = 0; tx_im[k] = 0; end
  endtask

  task automatic send_frame(input bit gaps);
    int guard;
    int idle;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        idle = $urandom_range(0, 2);
        repeat (idle) begin
          @(negedge clk);
          in_valid = 1'b0; in_re = $urandom; in_im = $urandom;
        end
      end
      @(negedge clk);
      in_valid = 1'b1; in_re = DW'(tx_re[k]); in_im = DW'(tx_im[k]);
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    e_cyc = cyc;
  endtask

  task automatic recv_frame(input int bp_n, input bit junk);
    int guard;
    bit comp_ok;
    bit stable;
    comp_ok = 1'b1;
    guard = 0;
    while (!out_valid && guard < 100) begin
      if (in_ready || !busy) comp_ok = 1'b0;
      if (junk) begin in_valid = 1'b1; in_re = $urandom; in_im = $urandom; end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1, 0);
      return;
    end
    chk("latency", cyc - e_cyc, 13, 0);
    chk("compute_in_ready_low", comp_ok, 1, 0);
    for (int n = 0; n < 8; n++) begin
      chk("out_valid", out_valid, 1, 0);
      rx_re[n] = $signed(out_re);
      rx_im[n] = $signed(out_im);
      chk("out_last", out_last, (n == 7) ? 1 : 0, 0);
      if (n == bp_n) begin
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!out_valid || $signed(out_re) != rx_re[n] || $signed(out_im) != rx_im[n] ||
              out_last != (n == 7)) stable = 1'b0;
        end
        chk("backpressure_hold", stable, 1, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("end_out_valid", out_valid, 0, 0);
    chk("end_in_ready", in_ready, 1, 0);
    chk("end_busy", busy, 0, 0);
  endtask

  // Reference: x[n] = (1/8) * sum X[k] * e^{+j*2*pi*k*n/8}
  task automatic check_model(input string tag, input int tol);
    real sr, si, a;
    for (int n = 0; n < 8; n++) begin
      sr = 0.0; si = 0.0;
      for (int k = 0; k < 8; k++) begin
        a = 2.0 * PI * k * n / 8.0;
        sr += tx_re[k] * $cos(a) - tx_im[k] * $sin(a);
        si += tx_re[k] * $sin(a) + tx_im[k] * $cos(a);
      end
      chk({tag, "_re"}, rx_re[n], rnd(sr / 8.0), tol);
      chk({tag, "_im"}, rx_im[n], rnd(si / 8.0), tol);
    end
  endtask

  task automatic check_impulse(input string tag);
    for (int n = 0; n < 8; n++) begin
      chk({tag, "_re"}, rx_re[n], 1000, 0);
      chk({tag, "_im"}, rx_im[n], 0, 0);
    end
  endtask

  initial begin
    real xr, xi, a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_out_last", out_last, 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_out_re", out_re, 0, 0);
    chk("rst_out_im", out_im, 0, 0);

    clear_tx(); tx_re[0] = 8000;
    send_frame(1'b0); recv_frame(-1, 1'b0);
    check_impulse("impulse");

    clear_tx(); tx_re[1] = 8000;
    send_frame(1'b0); recv_frame(3, 1'b0);
    check_model("tone", 2);
    chk("tone_n1_re", rx_re[1], 707, 2);
    chk("tone_n2_im", rx_im[2], 1000, 2);

    // Round trip: forward DFT of 10..80, then expect the sequence back
    for (int k = 0; k < 8; k++) begin
      xr = 0.0; xi = 0.0;
      for (int n = 0; n < 8; n++) begin
        a = 2.0 * PI * k * n / 8.0;
        xr += (10.0 * (n + 1)) * $cos(a);
        xi -= (10.0 * (n + 1)) * $sin(a);
      end
      tx_re[k] = rnd(xr); tx_im[k] = rnd(xi);
    end
    send_frame(1'b1); recv_frame(-1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      chk("roundtrip_re", rx_re[n], 10 * (n + 1), 2);
      chk("roundtrip_im", rx_im[n], 0, 2);
    end

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        tx_re[k] = int'($urandom_range(0, 8191)) - 4096;
        tx_im[k] = int'($urandom_range(0, 8191)) - 4096;
      end
      send_frame(1'b0); recv_frame(-1, 1'b0);
      check_model("random", 3);
      for (int n = 0; n < 8; n++) begin sv_re[n] = rx_re[n]; sv_im[n] = rx_im[n]; end
      send_frame(1'b1); recv_frame(f % 8, f[0]);
      for (int n = 0; n < 8; n++) begin
        chk("gaps_equal_re", rx_re[n], sv_re[n], 0);
        chk("gaps_equal_im", rx_im[n], sv_im[n], 0);
      end
    end

    // Reset in the middle of COMPUTE, then a clean impulse frame
    for (int k = 0; k < 8; k++) begin
      tx_re[k] = int'($urandom_range(0, 8191)) - 4096;
      tx_im[k] = int'($urandom_range(0, 8191)) - 4096;
    end
    send_frame(1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0, 0);
    chk("midrst_in_ready", in_ready, 1, 0);
    chk("midrst_busy", busy, 0, 0);
    chk("midrst_out_re", out_re, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tx(); tx_re[0] = 8000;
    send_frame(1'b0); recv_frame(-1, 1'b0);
    check_impulse("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
